// File: rtl/inst_buffer_pkg.sv
// Shared front-end definitions: the fetch packet format and instruction buffer sizing.
package inst_buffer_pkg;

    // Default instruction buffer depth (power of two, >= 2) and its pointer width.
    localparam int IB_DEPTH_DEF = 8;
    localparam int IB_PTR_W     = $clog2(IB_DEPTH_DEF);

    // One fetched instruction travelling from fetch to dispatch.
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
    } FETCH_PACKET;

endpackage

// File: rtl/inst_buffer.sv
// Instruction buffer: circular FIFO of fetch packets between fetch and dispatch.
// Head entry is presented from registered state only; squash or reset empties it.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int IB_DEPTH = IB_DEPTH_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  FETCH_PACKET               if_packet_in,
    input  logic                      dispatch_ready,
    input  logic                      squash,
    output FETCH_PACKET               if_packet_out,
    output logic                      fetch_stall,
    output logic [$clog2(IB_DEPTH):0] ib_count
);

    localparam int PTR_W = $clog2(IB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(IB_DEPTH);

    FETCH_PACKET      mem [IB_DEPTH];
    logic [PTR_W-1:0] head, head_nxt;
    logic [PTR_W-1:0] tail, tail_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             out_valid;
    logic             push, pop;

    // Next-state pointers/count and head-entry outputs; squash overrides push and pop.
    always_comb begin
        out_valid           = (count != '0) && !squash;
        if_packet_out       = mem[head];
        if_packet_out.valid = out_valid;
        fetch_stall         = (count == FULL);
        ib_count            = count;

        // A full buffer drops the push even when a pop frees a slot this cycle.
        push      = if_packet_in.valid && (count < FULL) && !squash;
        pop       = out_valid && dispatch_ready;
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;

        if (squash) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain truncation.
            if (push) tail_nxt = PTR_W'(tail + 1'b1);
            if (pop)  head_nxt = PTR_W'(head + 1'b1);
            if (push && !pop)      count_nxt = CNT_W'(count + 1'b1);
            else if (pop && !push) count_nxt = CNT_W'(count - 1'b1);
        end
    end

    // Storage write at tail plus pointer/count registers; reset beats everything.
    always_ff @(posedge clock) begin
        // Storage is not cleared on reset; count gates validity instead.
        if (push && !reset) mem[tail] <= if_packet_in;
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
        end
    end

endmodule
